bubble_processor: RTL and testbench

- Small 32-bit word-addressed load/store processor with Harvard instruction/data memories, a 32x32 register file and a single-cycle execute datapath.
- Memories are filled over a serial load port before execution starts.
- Raises end_signal on HALT.
- Exposes five debug words for bench monitoring; used as the top-level core for sorting demo programs.

---
 rtl/proc_pkg.sv | 54 +++++
 rtl/proc_alu.sv | 32 +++
 rtl/bubble_processor.sv | 200 ++++++++++++++++++++
 tb/tb_bubble_processor.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for bubble_processor: opcodes, functs, instruction field
// positions, FSM states and ALU operation codes.
`default_nettype none

package proc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000001;
  localparam logic [5:0] OP_LW    = 6'b000010;
  localparam logic [5:0] OP_SW    = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000110;
  localparam logic [5:0] OP_SLL   = 6'b000111;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_ADD = 6'b000000;
  localparam logic [5:0] FN_SUB = 6'b000001;
  localparam logic [5:0] FN_AND = 6'b000010;
  localparam logic [5:0] FN_OR  = 6'b000011;
  localparam logic [5:0] FN_SLT = 6'b000100;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int FN_MSB  = 5;
  localparam int IMM_MSB = 15;
  localparam int TGT_MSB = 25;

  localparam logic [4:0] DBG_REG = 5'd12;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4,
    ALU_SLL = 3'd5
  } alu_op_t;

endpackage

`default_nettype wire

// File: rtl/proc_alu.sv
// Combinational ALU for bubble_processor: 32-bit wrap arithmetic, logic,
// signed set-less-than and left shift, plus an operand equality flag.
`default_nettype none

module proc_alu
  import proc_pkg::*;
(
  input  alu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        equal
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {31'd0, $signed(a) < $signed(b)};
      ALU_SLL: result = a << b[4:0];
      default: result = '0;
    endcase
  end

  assign equal = (a == b);

endmodule

`default_nettype wire

// File: rtl/bubble_processor.sv
// bubble_processor: word-addressed load/store core with serial memory loading.
// Optional macro PROC_WATCHDOG_EN adds a MAX_CYCLES run-time watchdog.
`default_nettype none

module bubble_processor
  import proc_pkg::*;
#(
  parameter int IMEM_DEPTH = 64,
  parameter int DMEM_DEPTH = 64,
  parameter int DBG_ADDR   = 0,
  parameter int MAX_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_signal,
  input  logic [31:0] new_instruction,
  input  logic        add_into,
  output logic        end_signal,
  output logic [31:0] debug1,
  output logic [31:0] debug2,
  output logic [31:0] debug3,
  output logic [31:0] debug4,
  output logic [31:0] debug5
);

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);
  localparam logic [DAW-1:0] DBG_IDX = DBG_ADDR[DAW-1:0];

  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] dmem [DMEM_DEPTH];
  logic [31:0] regs [32];

  state_t          state, state_next;
  logic [IAW-1:0]  pc, pc_next, iptr;
  logic [DAW-1:0]  dptr, mem_addr;
  logic [31:0]     retired;

  logic [31:0] instr, rs_val, rt_val, imm_ext, alu_b, alu_result, wb_data;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, reg_dst;
  logic        reg_we, wb_mem, mem_we, is_halt, use_rt, alu_eq;
  logic        wd_fire, exec;
  alu_op_t     alu_op;

  assign instr   = imem[pc];
  assign opcode  = instr[OP_MSB:OP_LSB];
  assign rs      = instr[RS_MSB:RS_LSB];
  assign rt      = instr[RT_MSB:RT_LSB];
  assign rd      = instr[RD_MSB:RD_LSB];
  assign funct   = instr[FN_MSB:0];
  assign imm_ext = {{16{instr[IMM_MSB]}}, instr[IMM_MSB:0]};
  assign rs_val  = (rs == 5'd0) ? 32'd0 : regs[rs];
  assign rt_val  = (rt == 5'd0) ? 32'd0 : regs[rt];

  // Branches and R-type compare registers; everything else uses the immediate.
  assign use_rt = (opcode == OP_RTYPE) || (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign alu_b  = use_rt ? rt_val : imm_ext;

  always_comb begin
    alu_op = ALU_ADD;
    if (opcode == OP_RTYPE) begin
      case (funct)
        FN_SUB:  alu_op = ALU_SUB;
        FN_AND:  alu_op = ALU_AND;
        FN_OR:   alu_op = ALU_OR;
        FN_SLT:  alu_op = ALU_SLT;
        default: alu_op = ALU_ADD;
      endcase
    end else if (opcode == OP_SLL) begin
      alu_op = ALU_SLL;
    end
  end

  proc_alu u_alu (
    .op     (alu_op),
    .a      (rs_val),
    .b      (alu_b),
    .result (alu_result),
    .equal  (alu_eq)
  );

  assign mem_addr = alu_result[DAW-1:0];
  assign wb_data  = wb_mem ? dmem[mem_addr] : alu_result;

  always_comb begin
    reg_we  = 1'b0;
    reg_dst = rt;
    wb_mem  = 1'b0;
    mem_we  = 1'b0;
    is_halt = 1'b0;
    pc_next = pc + IAW'(1);
    case (opcode)
      OP_RTYPE: begin
        reg_dst = rd;
        reg_we  = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                  (funct == FN_OR)  || (funct == FN_SLT);
      end
      OP_ADDI: reg_we = 1'b1;
      OP_LW: begin
        reg_we = 1'b1;
        wb_mem = 1'b1;
      end
      OP_SW:   mem_we = 1'b1;
      OP_BEQ:  if (alu_eq)  pc_next = pc + IAW'(1) + imm_ext[IAW-1:0];
      OP_BNE:  if (!alu_eq) pc_next = pc + IAW'(1) + imm_ext[IAW-1:0];
      OP_J:    pc_next = instr[IAW-1:0];
      OP_SLL:  reg_we = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

`ifdef PROC_WATCHDOG_EN
  logic [31:0] wd_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if ((state == ST_RUN) && !wd_fire) begin
      wd_cnt <= wd_cnt + 32'd1;
    end
  end

  assign wd_fire = (state == ST_RUN) && (wd_cnt == 32'(MAX_CYCLES));
`else
  assign wd_fire = 1'b0;
`endif

  assign exec = (state == ST_RUN) && !wd_fire;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_LOAD;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_LOAD: if (start_signal) state_next = ST_RUN;
      ST_RUN:  if (wd_fire || is_halt) state_next = ST_DONE;
      default: state_next = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= '0;
      retired    <= '0;
      iptr       <= '0;
      dptr       <= '0;
      end_signal <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (!start_signal) begin
            if (add_into) dptr <= dptr + DAW'(1);
            else          iptr <= iptr + IAW'(1);
          end else begin
            pc <= '0;
          end
        end
        ST_RUN: begin
          if (wd_fire) begin
            end_signal <= 1'b1;
          end else begin
            retired <= retired + 32'd1;
            if (is_halt) begin
              end_signal <= 1'b1;
            end else begin
              pc <= pc_next;
              if (reg_we && (reg_dst != 5'd0)) regs[reg_dst] <= wb_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Memories survive reset; only the load port and sw can change them.
  always_ff @(posedge clk) begin
    if (!reset && (state == ST_LOAD) && !start_signal && !add_into)
      imem[iptr] <= new_instruction;
    if (!reset && (state == ST_LOAD) && !start_signal && add_into)
      dmem[dptr] <= new_instruction;
    else if (!reset && exec && mem_we)
      dmem[mem_addr] <= rt_val;
  end

  assign debug1 = retired;
  assign debug2 = 32'(pc);
  assign debug3 = dmem[DBG_IDX];
  assign debug4 = regs[DBG_REG];
  assign debug5 = instr;

endmodule

`default_nettype wire

// File: tb/tb_bubble_processor.sv
// Testbench for bubble_processor: instruction-level reference model checked
// every cycle, plus directed programs with hand-computed results.
`default_nettype none

module tb_bubble_processor;

  localparam int ID   = 64;
  localparam int DD   = 64;
  localparam int DBG  = 0;
  localparam int MAXC = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_signal = 1'b0;
  logic [31:0] new_instruction = '0;
  logic        add_into = 1'b0;
  logic        end_signal;
  logic [31:0] debug1, debug2, debug3, debug4, debug5;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  bubble_processor #(.IMEM_DEPTH(ID), .DMEM_DEPTH(DD), .DBG_ADDR(DBG), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .reset(reset), .start_signal(start_signal),
    .new_instruction(new_instruction), .add_into(add_into), .end_signal(end_signal),
    .debug1(debug1), .debug2(debug2), .debug3(debug3), .debug4(debug4), .debug5(debug5)
  );

  always #5 clk = ~clk;

  // Reference model: architectural state stepped once per rising edge.
  logic [31:0] m_imem [ID];
  logic [31:0] m_dmem [DD];
  logic [31:0] m_regs [32];
  int m_st, m_pc, m_ip, m_dp, m_wd;
  logic [31:0] m_cnt;
  logic m_end;

  function automatic int wrapi(int v);
    return ((v % ID) + ID) % ID;
  endfunction

  task automatic m_wr(int idx, logic [31:0] v);
    if (idx != 0) m_regs[idx] = v;
  endtask

  task automatic model_step();
    logic [31:0] ins, a, b, imm32;
    int op, fn, rs, rt, rd, npc;
    if (reset) begin
      m_st = 0; m_pc = 0; m_ip = 0; m_dp = 0; m_wd = 0; m_cnt = 0; m_end = 0;
      for (int i = 0; i < 32; i++) m_regs[i] = 0;
      return;
    end
    if (m_st == 0) begin
      if (!start_signal) begin
        if (add_into) begin m_dmem[m_dp] = new_instruction; m_dp = (m_dp + 1) % DD; end
        else          begin m_imem[m_ip] = new_instruction; m_ip = (m_ip + 1) % ID; end
      end else begin
        m_st = 1; m_pc = 0;
      end
    end else if (m_st == 1) begin
`ifdef PROC_WATCHDOG_EN
      if (m_wd == MAXC) begin m_st = 2; m_end = 1; return; end
      m_wd++;
`endif
      ins = m_imem[m_pc];
      op = int'(ins[31:26]); fn = int'(ins[5:0]);
      rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
      a = m_regs[rs]; b = m_regs[rt];
      imm32 = {{16{ins[15]}}, ins[15:0]};
      m_cnt = m_cnt + 1;
      npc = wrapi(m_pc + 1);
      case (op)
        0: case (fn)
             0: m_wr(rd, a + b);
             1: m_wr(rd, a - b);
             2: m_wr(rd, a & b);
             3: m_wr(rd, a | b);
             4: m_wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
             default: ;
           endcase
        1: m_wr(rt, a + imm32);
        2: m_wr(rt, m_dmem[(a + imm32) % DD]);
        3: m_dmem[(a + imm32) % DD] = b;
        4: if (a == b) npc = wrapi(m_pc + 1 + int'($signed(imm32)));
        5: if (a != b) npc = wrapi(m_pc + 1 + int'($signed(imm32)));
        6: npc = int'(ins[25:0]) % ID;
        7: m_wr(rt, a << ins[4:0]);
        63: begin m_st = 2; m_end = 1; npc = m_pc; end
        default: ;
      endcase
      m_pc = npc;
    end
  endtask

  always @(posedge clk) model_step();

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("end_signal", {31'd0, end_signal}, {31'd0, m_end});
      check("retired", debug1, m_cnt);
      check("pc", debug2, 32'(m_pc));
      check("dmem_dbg", debug3, m_dmem[DBG]);
      check("r12", debug4, m_regs[12]);
      check("instr", debug5, m_imem[m_pc]);
    end
  end

  function automatic logic [31:0] enc_r(logic [5:0] fn, logic [4:0] rd, logic [4:0] rs, logic [4:0] rt);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rt, logic [4:0] rs, int imm);
    logic [15:0] i16;
    i16 = 16'(imm);
    return {op, rs, rt, i16};
  endfunction

  localparam logic [31:0] HALT = 32'hFC00_0000;

  // Each driver task occupies exactly one rising edge.
  task automatic do_reset();
    @(negedge clk); reset = 1'b1; start_signal = 1'b0;
  endtask

  task automatic ld(input logic tgt, input logic [31:0] w);
    @(negedge clk); reset = 1'b0; start_signal = 1'b0; add_into = tgt; new_instruction = w;
  endtask

  task automatic run_until_end(input string name, input int limit);
    bit done = 1'b0;
    @(negedge clk); reset = 1'b0; start_signal = 1'b1;
    for (int c = 0; c < limit && !done; c++) begin
      @(negedge clk);
      if (end_signal) done = 1'b1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s: end_signal still 0 after %0d cycles, expected 1", name, limit);
    end
  endtask

  int sorted [10] = '{57, 64, 87, 242, 532, 573, 643, 805, 868, 879};
  int unsorted [10] = '{643, 573, 532, 87, 879, 242, 64, 805, 868, 57};

  initial begin
    // Give every memory word a known value so the model tracks it exactly.
    do_reset();
    for (int i = 0; i < ID; i++) ld(1'b0, 32'd0);
    for (int i = 0; i < DD; i++) ld(1'b1, 32'd0);
    do_reset();
    @(posedge clk); #1;
    chk_en = 1'b1;
    check("reset_end", {31'd0, end_signal}, 32'd0);
    check("reset_pc", debug2, 32'd0);
    check("reset_retired", debug1, 32'd0);

    // Basic load then run.
    ld(1'b0, enc_i(6'd1, 5'd12, 5'd0, 5));
    ld(1'b0, HALT);
    run_until_end("t1_run", 50);
    check("t1_r12", debug4, 32'd5);
    check("t1_end", {31'd0, end_signal}, 32'd1);
    check("t1_retired", debug1, 32'd2);
    check("t1_pc", debug2, 32'd1);
    repeat (3) @(negedge clk);
    check("t1_pc_frozen", debug2, 32'd1);
    check("t1_retired_frozen", debug1, 32'd2);

    // r0 writes discarded, unknown opcode NOP, slt -1 < 1.
    do_reset();
    ld(1'b0, enc_i(6'd1, 5'd0, 5'd0, 7));
    ld(1'b0, enc_i(6'd3, 5'd0, 5'd0, 0));
    ld(1'b0, enc_i(6'd1, 5'd1, 5'd0, -1));
    ld(1'b0, enc_i(6'd1, 5'd2, 5'd0, 1));
    ld(1'b0, 32'hA800_0000);
    ld(1'b0, enc_r(6'd4, 5'd12, 5'd1, 5'd2));
    ld(1'b0, HALT);
    run_until_end("t4_run", 50);
    check("t4_r0_store", debug3, 32'd0);
    check("t4_slt", debug4, 32'd1);
    check("t4_retired", debug1, 32'd7);
    check("t4_pc", debug2, 32'd6);

    // Data load, lw and sw.
    do_reset();
    ld(1'b1, 32'd10);
    ld(1'b1, 32'd643);
    ld(1'b0, enc_i(6'd2, 5'd1, 5'd0, 1));
    ld(1'b0, enc_i(6'd3, 5'd1, 5'd0, 0));
    ld(1'b0, HALT);
    run_until_end("t2_run", 50);
    check("t2_dmem0", debug3, 32'd643);
    check("t2_retired", debug1, 32'd3);

    // Counted loop with bne back-edge.
    do_reset();
    ld(1'b0, enc_i(6'd1, 5'd2, 5'd0, 3));
    ld(1'b0, enc_i(6'd1, 5'd1, 5'd1, 1));
    ld(1'b0, enc_i(6'd5, 5'd2, 5'd1, -2));
    ld(1'b0, enc_r(6'd0, 5'd12, 5'd1, 5'd0));
    ld(1'b0, HALT);
    run_until_end("t3_run", 100);
    check("t3_r12", debug4, 32'd3);
    check("t3_retired", debug1, 32'd9);

    // ALU mix, j and taken beq.
    do_reset();
    ld(1'b0, enc_i(6'd1, 5'd1, 5'd0, 12));
    ld(1'b0, enc_i(6'd1, 5'd2, 5'd0, 10));
    ld(1'b0, enc_r(6'd2, 5'd3, 5'd1, 5'd2));
    ld(1'b0, enc_r(6'd3, 5'd4, 5'd1, 5'd2));
    ld(1'b0, enc_r(6'd1, 5'd5, 5'd1, 5'd2));
    ld(1'b0, enc_i(6'd7, 5'd6, 5'd4, 2));
    ld(1'b0, enc_r(6'd0, 5'd7, 5'd3, 5'd5));
    ld(1'b0, enc_r(6'd0, 5'd12, 5'd7, 5'd6));
    ld(1'b0, {6'd6, 26'd10});
    ld(1'b0, enc_i(6'd1, 5'd12, 5'd0, 99));
    ld(1'b0, enc_i(6'd4, 5'd0, 5'd0, 1));
    ld(1'b0, enc_i(6'd1, 5'd12, 5'd0, 77));
    ld(1'b0, HALT);
    run_until_end("t5_run", 100);
    check("t5_r12", debug4, 32'd66);
    check("t5_retired", debug1, 32'd11);
    check("t5_pc", debug2, 32'd12);

    // Reset in the middle of a run of the same program.
    do_reset();
    @(negedge clk); reset = 1'b0; start_signal = 1'b1;
    repeat (9) @(negedge clk);
    check("mid_r12_before", debug4, 32'd66);
    do_reset();
    @(posedge clk); #1;
    check("mid_pc", debug2, 32'd0);
    check("mid_end", {31'd0, end_signal}, 32'd0);
    check("mid_r12", debug4, 32'd0);
    check("mid_retired", debug1, 32'd0);
    check("mid_dmem_kept", debug3, 32'd643);

    // Bubble sort of ten words.
    for (int i = 0; i < 10; i++) ld(1'b1, 32'(unsorted[i]));
    ld(1'b0, enc_i(6'd1, 5'd2, 5'd0, 9));
    ld(1'b0, enc_i(6'd1, 5'd3, 5'd0, 0));
    ld(1'b0, enc_i(6'd1, 5'd4, 5'd0, 0));
    ld(1'b0, enc_i(6'd2, 5'd5, 5'd4, 0));
    ld(1'b0, enc_i(6'd2, 5'd6, 5'd4, 1));
    ld(1'b0, enc_r(6'd4, 5'd7, 5'd6, 5'd5));
    ld(1'b0, enc_i(6'd4, 5'd0, 5'd7, 2));
    ld(1'b0, enc_i(6'd3, 5'd6, 5'd4, 0));
    ld(1'b0, enc_i(6'd3, 5'd5, 5'd4, 1));
    ld(1'b0, enc_i(6'd1, 5'd4, 5'd4, 1));
    ld(1'b0, enc_i(6'd5, 5'd2, 5'd4, -8));
    ld(1'b0, enc_i(6'd1, 5'd3, 5'd3, 1));
    ld(1'b0, enc_i(6'd5, 5'd2, 5'd3, -11));
    ld(1'b0, HALT);
    run_until_end("sort_run", 3000);
    check("sort_end", {31'd0, end_signal}, 32'd1);
    check("sort_dmem0", debug3, 32'd57);
    for (int i = 0; i < 10; i++) check($sformatf("sort_model_%0d", i), m_dmem[i], 32'(sorted[i]));

`ifdef PROC_WATCHDOG_EN
    do_reset();
    ld(1'b0, {6'd6, 26'd0});
    run_until_end("wd_run", MAXC + 20);
    check("wd_end", {31'd0, end_signal}, 32'd1);
    check("wd_retired", debug1, 32'(MAXC));
`endif

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
